// File: rtl/mul_arbiter.sv
// Purpose : round-robin scheduler sharing one sequential signed multiplier between N_REQ requesters.
// Latency : grant at t, mul_start at t+1, done at t+B+3 for a multiplier busy B cycles; one job in flight.
// Backpress: req is a level held until grant; no grant while a job runs or while mul_busy is high.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req                 per-requester request level
//   x_in, y_in          packed signed operands, slice i belongs to requester i
//   grant               one-hot pulse in the cycle the winner's operands are latched
//   done                one-hot pulse in the cycle resp_z/resp_id/resp_err are valid
//   resp_z, resp_id     product and requester index of the finished job (held until next job)
//   resp_err            job aborted by the watchdog (only with MUL_ARB_TIMEOUT_EN)
//   mul_x, mul_y        operands to the multiplier, stable from issue to done
//   mul_start           one-cycle start pulse to the multiplier
//   mul_busy, mul_z     multiplier busy flag and product
//
// Optional build macro MUL_ARB_TIMEOUT_EN adds a watchdog: more than 4 cycles waiting for
// mul_busy to rise, or more than WIDTH+4 cycles of busy, aborts the job with resp_err=1, resp_z=0.
// ID_W must satisfy 2**ID_W >= N_REQ.

module mul_arbiter #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] x_in,
    input  logic [N_REQ*WIDTH-1:0] y_in,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [2*WIDTH-1:0]     resp_z,
    output logic [ID_W-1:0]        resp_id,
    output logic                   resp_err,
    output logic [WIDTH-1:0]       mul_x,
    output logic [WIDTH-1:0]       mul_y,
    output logic                   mul_start,
    input  logic                   mul_busy,
    input  logic [2*WIDTH-1:0]     mul_z
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;

    logic             win_found;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W-1:0]  rr_nxt;
    logic [WIDTH-1:0] x_sel;
    logic [WIDTH-1:0] y_sel;
    logic             arb_go;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(WIDTH + 5);
    localparam logic [WD_W-1:0] WAIT_LIMIT = WD_W'(4);
    localparam logic [WD_W-1:0] RUN_LIMIT  = WD_W'(WIDTH + 4);

    logic [WD_W-1:0] wdog;
    logic            err_q;

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Round-robin search: offset i from rr_ptr picks requester j = (rr_ptr + i) mod N_REQ.
    // Both loops use constant indices so the operand mux stays a plain select tree.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        x_sel     = '0;
        y_sel     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!win_found && req[j] &&
                    ((int'(rr_ptr) + i == j) || (int'(rr_ptr) + i == j + N_REQ))) begin
                    win_found = 1'b1;
                    win_idx   = ID_W'(j);
                    x_sel     = x_in[j*WIDTH +: WIDTH];
                    y_sel     = y_in[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        if (int'(win_idx) == N_REQ - 1) begin
            rr_nxt = '0;
        end else begin
            rr_nxt = win_idx + 1'b1;
        end
    end

    // A new job may only start once the multiplier is idle; this also covers a
    // multiplier still finishing a job that was dropped by reset.
    assign arb_go = rst_n && (state == S_IDLE) && win_found && !mul_busy;

    // grant is a decode of the arbitration result in the cycle the operands are latched.
    assign grant = arb_go ? (REQ_ONE << win_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            mul_x     <= '0;
            mul_y     <= '0;
            mul_start <= 1'b0;
            done      <= '0;
            resp_z    <= '0;
            resp_id   <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            wdog      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            done      <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (arb_go) begin
                        mul_x     <= x_sel;
                        mul_y     <= y_sel;
                        id_q      <= win_idx;
                        rr_ptr    <= rr_nxt;
                        mul_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    state <= S_WAIT_BUSY;
`ifdef MUL_ARB_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end

                S_WAIT_BUSY: begin
                    if (mul_busy) begin
                        state <= S_RUN;
`ifdef MUL_ARB_TIMEOUT_EN
                        wdog  <= '0;
`endif
                    end
`ifdef MUL_ARB_TIMEOUT_EN
                    else if (wdog == WAIT_LIMIT) begin
                        // Multiplier never acknowledged the start: abort.
                        resp_z  <= '0;
                        resp_id <= id_q;
                        err_q   <= 1'b1;
                        done    <= REQ_ONE << id_q;
                        state   <= S_DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end

                S_RUN: begin
                    // First cycle with busy low after it was high: product is final.
                    if (!mul_busy) begin
                        resp_z  <= mul_z;
                        resp_id <= id_q;
                        done    <= REQ_ONE << id_q;
                        state   <= S_DONE;
                    end
`ifdef MUL_ARB_TIMEOUT_EN
                    else if (wdog == RUN_LIMIT) begin
                        // Multiplier stuck busy: abort so other requesters keep moving.
                        resp_z  <= '0;
                        resp_id <= id_q;
                        err_q   <= 1'b1;
                        done    <= REQ_ONE << id_q;
                        state   <= S_DONE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural sequential multiplier.
// The multiplier model raises mul_busy the cycle after it sees mul_start and
// holds it for mdl_b cycles, presenting the signed product when busy falls.

module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] x_in = '0;
    logic [63:0] y_in = '0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [31:0] resp_z;
    logic [1:0]  resp_id;
    logic        resp_err;
    logic [15:0] mul_x;
    logic [15:0] mul_y;
    logic        mul_start;
    logic        mul_busy = 1'b0;
    logic [31:0] mul_z = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mdl_b = 4;
    bit mdl_en = 1'b1;

    mul_arbiter #(.WIDTH(16), .N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .grant     (grant),
        .done      (done),
        .resp_z    (resp_z),
        .resp_id   (resp_id),
        .resp_err  (resp_err),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_start (mul_start),
        .mul_busy  (mul_busy),
        .mul_z     (mul_z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model
    always begin
        logic signed [31:0] prod;
        @(posedge clk);
        if (mul_start && mdl_en) begin
            #1 mul_busy = 1'b1;
            repeat (mdl_b) @(posedge clk);
            #1;
            prod     = $signed(mul_x) * $signed(mul_y);
            mul_z    = prod;
            mul_busy = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic apply_reset;
        @(posedge clk);
        #1 rst_n = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Runs one job for a single requester and reports what was observed.
    // lat is done cycle minus grant cycle, -1 if grant or done never came.
    task automatic do_job(input int idx, input logic [15:0] x, input logic [15:0] y,
                          input int b, output int lat, output logic st,
                          output logic [3:0] g, output logic [3:0] d,
                          output logic [31:0] z, output logic [1:0] id, output logic err);
        int tg;
        int n;
        lat = -1; st = 1'b0; g = '0; d = '0; z = '0; id = '0; err = 1'b0;
        @(posedge clk);
        #1;
        mdl_b = b;
        x_in[idx*16 +: 16] = x;
        y_in[idx*16 +: 16] = y;
        req = 4'b0001 << idx;
        n = 0;
        @(negedge clk);
        while (grant == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (grant == '0) begin
            req = '0;
            return;
        end
        g  = grant;
        tg = cyc;
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        st = mul_start;
        n = 0;
        @(negedge clk);
        while (done == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done == '0) return;
        lat = cyc - tg;
        d   = done;
        z   = resp_z;
        id  = resp_id;
        err = resp_err;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 4'b0)      begin failures++; $display("FAIL reset_grant got=%h exp=0", grant); end
        checks++; if (done !== 4'b0)       begin failures++; $display("FAIL reset_done got=%h exp=0", done); end
        checks++; if (resp_z !== 32'h0)    begin failures++; $display("FAIL reset_resp_z got=%h exp=0", resp_z); end
        checks++; if (resp_id !== 2'h0)    begin failures++; $display("FAIL reset_resp_id got=%h exp=0", resp_id); end
        checks++; if (resp_err !== 1'b0)   begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        checks++; if (mul_x !== 16'h0)     begin failures++; $display("FAIL reset_mul_x got=%h exp=0", mul_x); end
        checks++; if (mul_y !== 16'h0)     begin failures++; $display("FAIL reset_mul_y got=%h exp=0", mul_y); end
        checks++; if (mul_start !== 1'b0)  begin failures++; $display("FAIL reset_mul_start got=%b exp=0", mul_start); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single;
        int lat; logic st; logic [3:0] g, d; logic [31:0] z; logic [1:0] id; logic err;
        do_job(0, 16'd3, 16'hFFFB, 16, lat, st, g, d, z, id, err);
        checks++; if (g !== 4'b0001)       begin failures++; $display("FAIL single_grant got=%h exp=1", g); end
        checks++; if (st !== 1'b1)         begin failures++; $display("FAIL single_start_t1 got=%b exp=1", st); end
        checks++; if (lat !== 19)          begin failures++; $display("FAIL single_latency got=%0d exp=19", lat); end
        checks++; if (d !== 4'b0001)       begin failures++; $display("FAIL single_done got=%h exp=1", d); end
        checks++; if (z !== 32'hFFFFFFF1)  begin failures++; $display("FAIL single_resp_z got=%h exp=fffffff1", z); end
        checks++; if (id !== 2'd0)         begin failures++; $display("FAIL single_resp_id got=%0d exp=0", id); end
        checks++; if (err !== 1'b0)        begin failures++; $display("FAIL single_resp_err got=%b exp=0", err); end
        @(negedge clk);
        checks++; if (done !== 4'b0)       begin failures++; $display("FAIL single_done_pulse got=%h exp=0", done); end
        checks++; if (resp_z !== 32'hFFFFFFF1) begin failures++; $display("FAIL single_resp_hold got=%h exp=fffffff1", resp_z); end
    endtask

    task automatic test_round_robin;
        int exp_i;
        int n;
        apply_reset();
        @(posedge clk);
        #1;
        mdl_b = 2;
        for (int i = 0; i < 4; i++) begin
            x_in[i*16 +: 16] = 16'(i + 1);
            y_in[i*16 +: 16] = 16'd2;
        end
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_i = j % 4;
            n = 0;
            @(negedge clk);
            while (grant == '0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            checks++; if (grant !== (4'b0001 << exp_i)) begin failures++; $display("FAIL rr_grant job=%0d got=%h exp=%h", j, grant, 4'b0001 << exp_i); end
            n = 0;
            @(negedge clk);
            while (done == '0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            checks++; if (done !== (4'b0001 << exp_i)) begin failures++; $display("FAIL rr_done job=%0d got=%h exp=%h", j, done, 4'b0001 << exp_i); end
            checks++; if (resp_id !== 2'(exp_i))       begin failures++; $display("FAIL rr_resp_id job=%0d got=%0d exp=%0d", j, resp_id, exp_i); end
            checks++; if (resp_z !== 32'(2 * (exp_i + 1))) begin failures++; $display("FAIL rr_resp_z job=%0d got=%h exp=%h", j, resp_z, 2 * (exp_i + 1)); end
        end
        @(posedge clk);
        #1 req = '0;
    endtask

    task automatic test_extremes;
        int lat; logic st; logic [3:0] g, d; logic [31:0] z; logic [1:0] id; logic err;
        do_job(1, 16'h8000, 16'h8000, 5, lat, st, g, d, z, id, err);
        checks++; if (z !== 32'h40000000)  begin failures++; $display("FAIL ext_minmin_z got=%h exp=40000000", z); end
        checks++; if (lat !== 8)           begin failures++; $display("FAIL ext_minmin_latency got=%0d exp=8", lat); end
        checks++; if (d !== 4'b0010)       begin failures++; $display("FAIL ext_minmin_done got=%h exp=2", d); end
        do_job(3, 16'h7FFF, 16'h8000, 3, lat, st, g, d, z, id, err);
        checks++; if (z !== 32'hC0008000)  begin failures++; $display("FAIL ext_maxmin_z got=%h exp=c0008000", z); end
        checks++; if (id !== 2'd3)         begin failures++; $display("FAIL ext_maxmin_id got=%0d exp=3", id); end
        checks++; if (d !== 4'b1000)       begin failures++; $display("FAIL ext_maxmin_done got=%h exp=8", d); end
    endtask

    task automatic test_operand_stability;
        int n;
        bit moved;
        @(posedge clk);
        #1;
        mdl_b = 6;
        x_in[32 +: 16] = 16'd100;
        y_in[32 +: 16] = 16'hFFF9;
        req = 4'b0100;
        n = 0;
        @(negedge clk);
        while (grant == '0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL stab_grant got=%h exp=4", grant); end
        @(posedge clk);
        #1;
        x_in[32 +: 16] = 16'h1234;
        y_in[32 +: 16] = 16'd5;
        req = '0;
        moved = 1'b0;
        n = 0;
        @(negedge clk);
        while (done == '0 && n < 40) begin
            if (mul_x !== 16'd100 || mul_y !== 16'hFFF9) moved = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++; if (moved !== 1'b0)        begin failures++; $display("FAIL stab_operands moved=%b exp=0", moved); end
        checks++; if (done !== 4'b0100)      begin failures++; $display("FAIL stab_done got=%h exp=4", done); end
        checks++; if (resp_z !== 32'hFFFFFD44) begin failures++; $display("FAIL stab_resp_z got=%h exp=fffffd44", resp_z); end
    endtask

    task automatic test_reset_run;
        int n;
        bit saw_done;
        logic busy_at_grant;
        @(posedge clk);
        #1;
        mdl_b = 30;
        x_in = {16'd4, 16'd3, 16'd2, 16'd1};
        y_in = {4{16'd2}};
        req = 4'b1000;
        n = 0;
        @(negedge clk);
        while (grant == '0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL rrun_grant got=%h exp=8", grant); end
        @(posedge clk);
        #1 req = '0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (resp_z !== 32'h0)  begin failures++; $display("FAIL rrun_resp_z got=%h exp=0", resp_z); end
        checks++; if (mul_x !== 16'h0 || mul_y !== 16'h0) begin failures++; $display("FAIL rrun_operands got=%h/%h exp=0/0", mul_x, mul_y); end
        checks++; if (done !== 4'b0 || grant !== 4'b0 || mul_start !== 1'b0) begin failures++; $display("FAIL rrun_pulses done=%h grant=%h start=%b exp=0", done, grant, mul_start); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 4'b1111;
        mdl_b = 3;
        saw_done = 1'b0;
        n = 0;
        @(negedge clk);
        while (grant == '0 && n < 60) begin
            if (done != '0) saw_done = 1'b1;
            @(negedge clk);
            n++;
        end
        busy_at_grant = mul_busy;
        checks++; if (grant !== 4'b0001)      begin failures++; $display("FAIL rrun_resume_grant got=%h exp=1", grant); end
        checks++; if (busy_at_grant !== 1'b0) begin failures++; $display("FAIL rrun_grant_while_busy busy=%b exp=0", busy_at_grant); end
        checks++; if (saw_done !== 1'b0)      begin failures++; $display("FAIL rrun_dropped_done seen=%b exp=0", saw_done); end
        @(posedge clk);
        #1 req = '0;
        n = 0;
        @(negedge clk);
        while (done == '0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (done !== 4'b0001)    begin failures++; $display("FAIL rrun_done got=%h exp=1", done); end
        checks++; if (resp_z !== 32'd2)    begin failures++; $display("FAIL rrun_resp_z_after got=%h exp=2", resp_z); end
    endtask

    task automatic test_timeout;
        int lat; logic st; logic [3:0] g, d; logic [31:0] z; logic [1:0] id; logic err;
        mdl_en = 1'b0;
        do_job(1, 16'd9, 16'd9, 4, lat, st, g, d, z, id, err);
        checks++; if (g !== 4'b0010) begin failures++; $display("FAIL tmo_grant got=%h exp=2", g); end
`ifdef MUL_ARB_TIMEOUT_EN
        checks++; if (lat !== 7)      begin failures++; $display("FAIL tmo_latency got=%0d exp=7", lat); end
        checks++; if (err !== 1'b1)   begin failures++; $display("FAIL tmo_resp_err got=%b exp=1", err); end
        checks++; if (z !== 32'h0)    begin failures++; $display("FAIL tmo_resp_z got=%h exp=0", z); end
        checks++; if (d !== 4'b0010)  begin failures++; $display("FAIL tmo_done got=%h exp=2", d); end
`else
        checks++; if (lat !== -1)     begin failures++; $display("FAIL tmo_no_done latency=%0d exp=-1", lat); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL tmo_resp_err got=%b exp=0", resp_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_extremes();
        test_operand_stability();
        test_reset_run();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Round-robin scheduler that shares one sequential signed multiplier between N_REQ requesters.
- Grants one requester at a time and latches its operands.
- Sequences the multiplier through its start/busy handshake, captures the product and returns it with a per-requester done pulse.
- Sits between requester blocks (ALU lanes, DSP stages) and the single multiplier instance.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH.
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of resp_id; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  request per requester; level, held until grant.
- x_in  in  N_REQ*WIDTH  signed multiplicand; slice i belongs to requester i.
- y_in  in  N_REQ*WIDTH  signed multiplier; slice i belongs to requester i.
- grant  out  N_REQ  one-hot, one-cycle pulse; operands of that requester latched this cycle.
- done  out  N_REQ  one-hot, one-cycle pulse; resp_z/resp_id valid this cycle.
- resp_z  out  2*WIDTH  product of the finished job.
- resp_id  out  ID_W  index of the finished requester.
- resp_err  out  1  job aborted; see Optional Feature.
- mul_x  out  WIDTH  operand to multiplier; stable from ISSUE until DONE.
- mul_y  out  WIDTH  operand to multiplier; stable from ISSUE until DONE.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_busy  in  1  multiplier busy; product final on first cycle busy is low after being high.
- mul_z  in  2*WIDTH  multiplier product.

Behaviour:
- Reset values: grant=0, done=0, resp_z=0, resp_id=0, resp_err=0, mul_x=0, mul_y=0, mul_start=0; state IDLE; rr_ptr=0; all latches cleared.
- Reset is asynchronous and may occur mid-job: the job is dropped with no done pulse. The controller still waits for mul_busy low in IDLE before it grants.
- States: IDLE, ISSUE, WAIT_BUSY, RUN, DONE.
- IDLE:
  - Grants only if |req and mul_busy==0.
  - Winner is the first set req bit searching upward from rr_ptr, wrapping at N_REQ-1 to 0.
  - In the grant cycle: grant[winner]=1, x_in/y_in slices latched into mul_x/mul_y, id latched, rr_ptr <= (winner+1) mod N_REQ. Next state is ISSUE.
- ISSUE: mul_start=1 for exactly this cycle; next state is WAIT_BUSY.
- WAIT_BUSY: stays until mul_busy sampled 1, then goes to RUN.
- RUN:
  - Stays while mul_busy=1.
  - On the first cycle mul_busy sampled 0: resp_z <= mul_z, next state is DONE.
- DONE: done[id]=1, resp_id=id, resp_err=0 for one cycle; next state is IDLE.
- resp_z and resp_id hold their values after DONE until the next capture.
- Latency: grant at cycle t, mul_start at t+1. If mul_busy is high for B cycles starting at t+2, done occurs at t+B+3.
- Back-to-back: the earliest next grant is the cycle after DONE, so at most one job is in flight. Throughput is B+4 cycles per job.
- A requester may keep req high after its grant; that requests a new job, arbitrated fairly against the others.
- req changes and x_in/y_in changes after grant do not affect the running job.
- req deasserted before grant: the request is withdrawn and nothing is issued for it.
- Simultaneous reqs: exactly one grant per arbitration. Every continuously asserting requester is served within N_REQ jobs.
- Operands are passed through unmodified (two's complement); product width is 2*WIDTH, with no truncation or saturation.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- With the macro, watchdog counter limits:
  - WAIT_BUSY longer than 4 cycles aborts.
  - RUN longer than WIDTH+4 cycles aborts.
  - On abort: go to DONE with resp_err=1 and resp_z=0, then IDLE. rr_ptr already advanced, so the faulty requester does not starve others.
- Without the macro: no counter, resp_err tied 0, and WAIT_BUSY/RUN wait indefinitely.

Test Plan:
- Single job: req=4'b0001, x=3, y=-5; multiplier busy 16 cycles -> grant[0] at t, mul_start at t+1, done[0] at t+19, resp_z=-15 (0xFFFFFFF1), resp_id=0.
- Round-robin: req=4'b1111 held for 5 jobs -> grant order 0,1,2,3,0; exactly one done per job, matching the grant order.
- Extremes: x=-32768, y=-32768 -> resp_z=0x40000000; x=32767, y=-32768 -> resp_z=0xC0008000.
- Operand stability: change x_in/y_in and drop req[2] one cycle after grant[2] -> mul_x/mul_y unchanged until done[2]; product uses the latched values.
- Reset during RUN: rst_n low for 2 cycles with mul_busy still high -> all outputs 0, no done pulse; no grant until mul_busy falls, then arbitration resumes from requester 0.
- With MUL_ARB_TIMEOUT_EN: mul_busy never rises after mul_start -> done at ISSUE+6 with resp_err=1, resp_z=0. Without the macro, same stimulus -> no done.
